// File: rtl/accel_bus_scheduler.sv
// Round-robin time-sharing of the RAM data bus among the FFT, FIR and IIR accelerators,
// with burst/stall-bounded grants and a one-cycle all-off turnaround between grants.
module accel_bus_scheduler #(
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fft_req,
  input  logic       fir_req,
  input  logic       iir_req,
  input  logic       xfer_active,
  output logic       fft_enable,
  output logic       fir_enable,
  output logic       iir_enable,
  output logic [1:0] owner,
  output logic [7:0] burst_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);
  localparam logic [7:0] STALL_MAX = 8'(STALL_LIMIT);

  // Requester index: 0 = FFT, 1 = FIR, 2 = IIR; owner code is index + 1.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic req_at(input logic [1:0] i, input logic [2:0] r);
    case (i)
      2'd0:    return r[0];
      2'd1:    return r[1];
      2'd2:    return r[2];
      default: return 1'b0;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] stall_q, stall_d;
  logic [7:0] burst_d;
  logic [1:0] owner_d;
  logic [2:0] en_d;
  logic       busy_d;
  logic [2:0] req;
  logic [1:0] c0, c1, c2;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] owner_idx;

  assign req       = {iir_req, fir_req, fft_req};
  assign owner_idx = owner - 2'd1;
  assign c0        = ptr_q;
  assign c1        = next_idx(c0);
  assign c2        = next_idx(c1);

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    pick_valid = 1'b1;
    pick_idx   = c0;
    if (req_at(c0, req))      pick_idx = c0;
    else if (req_at(c1, req)) pick_idx = c1;
    else if (req_at(c2, req)) pick_idx = c2;
    else                      pick_valid = 1'b0;
  end

  // State register; the registered outputs live here too so they reset asynchronously.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      stall_q     <= 8'd0;
      owner       <= 2'd0;
      burst_count <= 8'd0;
      fft_enable  <= 1'b0;
      fir_enable  <= 1'b0;
      iir_enable  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      stall_q     <= stall_d;
      owner       <= owner_d;
      burst_count <= burst_d;
      fft_enable  <= en_d[0];
      fir_enable  <= en_d[1];
      iir_enable  <= en_d[2];
      busy        <= busy_d;
    end
  end

  // Next-state logic. IDLE and GAP arbitrate identically; GAP exists only to force the off-cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    burst_d = burst_count;
    owner_d = owner;
    unique case (state_q)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx + 2'd1;
          burst_d = 8'd0;
          stall_d = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (xfer_active) begin
          burst_d = burst_count + 8'd1;
          stall_d = 8'd0;
        end else begin
          stall_d = stall_q + 8'd1;
        end
        // Any combination of causes collapses into one release.
        if (burst_d == BURST_MAX || stall_d == STALL_MAX || !req_at(owner_idx, req)) begin
          state_d = GAP;
          owner_d = 2'd0;
          ptr_d   = next_idx(owner_idx);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the next owner; registered alongside the state.
  always_comb begin
    en_d   = 3'b000;
    busy_d = 1'b0;
    case (owner_d)
      2'd1:    en_d = 3'b001;
      2'd2:    en_d = 3'b010;
      2'd3:    en_d = 3'b100;
      default: en_d = 3'b000;
    endcase
    busy_d = (owner_d != 2'd0);
  end

endmodule

// File: tb/tb_accel_bus_scheduler.sv
// Scoreboard bench for accel_bus_scheduler: a behavioural model predicts the outputs after
// every clock edge, a negedge monitor pops and compares them against the DUT.
module tb_accel_bus_scheduler;

  localparam int BURST = 16;
  localparam int STALL = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       fft_req, fir_req, iir_req, xfer_active;
  logic       fft_enable, fir_enable, iir_enable;
  logic [1:0] owner;
  logic [7:0] burst_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] en;     // {iir, fir, fft}
    logic [1:0] owner;
    logic [7:0] burst;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];

  // Behavioural model: who holds the bus (-1 = nobody), rotation start, counters.
  int m_cur, m_ptr, m_burst, m_stall;

  accel_bus_scheduler #(.BURST_LEN(BURST), .STALL_LIMIT(STALL)) dut (
    .clk(clk), .reset(reset),
    .fft_req(fft_req), .fir_req(fir_req), .iir_req(iir_req), .xfer_active(xfer_active),
    .fft_enable(fft_enable), .fir_enable(fir_enable), .iir_enable(iir_enable),
    .owner(owner), .burst_count(burst_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual en=%b owner=%b burst=%0d busy=%b required en=%b owner=%b burst=%0d busy=%b",
               name, $time, act.en, act.owner, act.burst, act.busy,
               exp.en, exp.owner, exp.burst, exp.busy);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.en    = {iir_enable, fir_enable, fft_enable};
    o.owner = owner;
    o.burst = burst_count;
    o.busy  = busy;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.en    = (m_cur < 0) ? 3'b000 : 3'(1 << m_cur);
    o.owner = (m_cur < 0) ? 2'd0 : 2'(m_cur + 1);
    o.burst = 8'(m_burst);
    o.busy  = (m_cur >= 0);
    return o;
  endfunction

  function automatic void model_reset();
    m_cur = -1; m_ptr = 0; m_burst = 0; m_stall = 0;
  endfunction

  // Advance the model by one clock edge with the given request vector {iir,fir,fft}.
  function automatic void model_step(input logic [2:0] r, input logic x);
    if (m_cur >= 0) begin
      if (x) begin m_burst++; m_stall = 0; end
      else   m_stall++;
      if (m_burst == BURST || m_stall == STALL || !r[m_cur]) begin
        m_ptr = (m_cur + 1) % 3;
        m_cur = -1;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_cur < 0 && r[(m_ptr + k) % 3]) m_cur = (m_ptr + k) % 3;
      end
      if (m_cur >= 0) begin m_burst = 0; m_stall = 0; end
    end
  endfunction

  // Apply inputs for one edge, predict the result, wait past the edge.
  task automatic cycle(input logic [2:0] r, input logic x);
    {iir_req, fir_req, fft_req} = r;
    xfer_active = x;
    model_step(r, x);
    exp_q.push_back(model_obs());
    @(posedge clk); #1;
  endtask

  // Asynchronous reset with an immediate no-clock check, released during clock-low.
  task automatic do_reset(input logic [2:0] r_during);
    @(negedge clk); #1;
    reset = 1'b0;
    {iir_req, fir_req, fft_req} = r_during;
    #1;
    check("async_reset", sample(), obs_t'(14'd0));
    model_reset();
    @(negedge clk); #1;
    check("reset_hold", sample(), obs_t'(14'd0));
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check("cycle", sample(), exp_q.pop_front());
  end

  initial begin
    logic [2:0] r;
    reset = 1'b0;
    {iir_req, fir_req, fft_req} = 3'b000;
    xfer_active = 1'b0;
    model_reset();
    #12;
    check("reset_state", sample(), obs_t'(14'd0));
    @(negedge clk); #1;
    reset = 1'b1;

    // FIR alone, continuous transfers: 16-cycle grants separated by one off-cycle.
    for (int i = 0; i < 40; i++) cycle(3'b010, 1'b1);

    // Everyone requesting: FFT, FIR, IIR, FFT rotation.
    do_reset(3'b000);
    for (int i = 0; i < 72; i++) cycle(3'b111, 1'b1);

    // FFT owns the bus with no transfers while FIR waits: stall release then FIR.
    do_reset(3'b000);
    for (int i = 0; i < 25; i++) cycle(3'b011, 1'b0);

    // IIR alone, drops its request after 5 transfers.
    do_reset(3'b000);
    for (int i = 0; i < 6; i++) cycle(3'b100, 1'b1);
    for (int i = 0; i < 6; i++) cycle(3'b000, 1'b0);

    // Reset mid-burst at burst_count 7, then all request: FFT must win first.
    do_reset(3'b000);
    for (int i = 0; i < 8; i++) cycle(3'b001, 1'b1);
    do_reset(3'b111);
    for (int i = 0; i < 20; i++) cycle(3'b111, 1'b1);

    // No requests for 100 cycles with xfer_active toggling.
    for (int i = 0; i < 100; i++) cycle(3'b000, 1'(i % 2));

    // Randomised: sticky requests that occasionally toggle, mostly-busy transfers.
    r = 3'b000;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      cycle(r, $urandom_range(0, 3) != 0);
    end

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
